fifo_fwft_prog: RTL and testbench

//  Self-contained parametrised FIFO, selectable FWFT or standard read mode.

---
 rtl/fifo_fwft_prog_pkg.sv | 16 +
 rtl/fifo_fwft_ram.sv | 38 +++
 rtl/fifo_fwft_prog.sv | 119 +++++++++++
 tb/tb_fifo_fwft_prog.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_fwft_prog_pkg.sv
// Shared types and width helpers for the programmable FWFT/standard FIFO.
package fifo_fwft_prog_pkg;

  // Read-side behaviour of the FIFO
  typedef enum logic [0:0] {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Pointers and the occupancy count carry one extra bit: the pointer wrap bit,
  // which also lets the count reach the full RAM depth (plus the FWFT output word).
  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_fwft_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with an
// output register that only loads on a read strobe, so the word holds between reads.
module fifo_fwft_ram #(
  parameter int unsigned DataW = 32,
  parameter int unsigned AddrW = 4
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_we,
  input  logic [AddrW-1:0] i_waddr,
  input  logic [DataW-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AddrW-1:0] i_raddr,
  output logic [DataW-1:0] o_rdata
);

  logic [DataW-1:0] r_mem [2**AddrW];
  logic [DataW-1:0] r_rdata;

  // Storage array is left unreset so it can map onto block RAM
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port; cleared on reset so dout starts at zero
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_fwft_prog.sv
// Single-clock FIFO with selectable first-word-fall-through or standard read,
// occupancy count, programmable almost-full/almost-empty and sticky error flags.
module fifo_fwft_prog
  import fifo_fwft_prog_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned FWFT_MODE     = 1,
  parameter int unsigned AFULL_THRESH  = 14,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic                  o_full,
  output logic                  o_almost_full,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic                  o_empty,
  output logic                  o_almost_empty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow,
  input  logic                  i_clr_err
);

  localparam int unsigned     PtrW     = ptr_width(ADDR_WIDTH);
  localparam fifo_mode_e      Mode     = (FWFT_MODE != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [PtrW-1:0] AFullTh  = PtrW'(AFULL_THRESH);
  localparam logic [PtrW-1:0] AEmptyTh = PtrW'(AEMPTY_THRESH);

  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_count;
  logic            r_out_valid;
  logic            r_overflow;
  logic            r_underflow;

  logic w_ram_empty;
  logic w_full;
  logic w_wr_acc;
  logic w_ram_rd;
  logic w_pop;
  logic w_empty;
  logic w_rd_err;

  // Pointer compare, read strobe and pop decode for the selected read mode
  always_comb begin
    w_ram_empty = (r_wr_ptr == r_rd_ptr);
    w_full      = (r_wr_ptr[PtrW-2:0] == r_rd_ptr[PtrW-2:0]) &&
                  (r_wr_ptr[PtrW-1] != r_rd_ptr[PtrW-1]);
    // Full is judged before any concurrent read frees a slot
    w_wr_acc    = i_wr_en & ~w_full;
    if (Mode == FIFO_FWFT) begin
      // Refill the output register whenever it is empty or being consumed
      w_ram_rd = ~w_ram_empty & (~r_out_valid | i_rd_en);
      w_pop    = i_rd_en & r_out_valid;
      w_empty  = ~r_out_valid;
    end else begin
      w_ram_rd = i_rd_en & ~w_ram_empty;
      w_pop    = w_ram_rd;
      w_empty  = w_ram_empty;
    end
    w_rd_err = i_rd_en & w_empty;
  end

  // Pointers, occupancy, output-valid and sticky error flags
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_ram_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      // In FWFT the RAM-to-output move is count neutral; only a pop leaves
      unique case ({w_wr_acc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_ram_rd)     r_out_valid <= 1'b1;
      else if (i_rd_en) r_out_valid <= 1'b0;
      // A new error in the same cycle as clr_err keeps the flag set
      r_overflow  <= (r_overflow  & ~i_clr_err) | (i_wr_en & w_full);
      r_underflow <= (r_underflow & ~i_clr_err) | w_rd_err;
    end
  end

  fifo_fwft_ram #(
    .DataW (DATA_WIDTH),
    .AddrW (ADDR_WIDTH)
  ) u_ram (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_we     (w_wr_acc),
    .i_waddr  (r_wr_ptr[PtrW-2:0]),
    .i_wdata  (i_din),
    .i_re     (w_ram_rd),
    .i_raddr  (r_rd_ptr[PtrW-2:0]),
    .o_rdata  (o_dout)
  );

  // Status outputs decode straight from registered state
  always_comb begin
    o_full         = w_full;
    o_empty        = w_empty;
    o_count        = r_count;
    o_almost_full  = (r_count >= AFullTh);
    o_almost_empty = (r_count <= AEmptyTh);
    o_overflow     = r_overflow;
    o_underflow    = r_underflow;
  end

endmodule

// File: tb/tb_fifo_fwft_prog.sv
// Directed self-checking bench: one FWFT instance and one standard-mode
// instance share stimulus; each phase starts from reset.
module tb_fifo_fwft_prog;

  logic        clk;
  logic        arst_n;
  logic        wr_en;
  logic [31:0] din;
  logic        rd_en;
  logic        clr_err;

  logic        f_full, f_afull, f_empty, f_aempty, f_ovf, f_udf;
  logic [31:0] f_dout;
  logic [4:0]  f_count;
  logic        s_full, s_afull, s_empty, s_aempty, s_ovf, s_udf;
  logic [31:0] s_dout;
  logic [4:0]  s_count;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_fwft_prog #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .FWFT_MODE(1), .AFULL_THRESH(14), .AEMPTY_THRESH(2)
  ) u_fwft (
    .i_clk(clk), .i_arst_n(arst_n), .i_wr_en(wr_en), .i_din(din), .o_full(f_full),
    .o_almost_full(f_afull), .i_rd_en(rd_en), .o_dout(f_dout), .o_empty(f_empty),
    .o_almost_empty(f_aempty), .o_count(f_count), .o_overflow(f_ovf),
    .o_underflow(f_udf), .i_clr_err(clr_err)
  );

  fifo_fwft_prog #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .FWFT_MODE(0), .AFULL_THRESH(14), .AEMPTY_THRESH(2)
  ) u_std (
    .i_clk(clk), .i_arst_n(arst_n), .i_wr_en(wr_en), .i_din(din), .o_full(s_full),
    .o_almost_full(s_afull), .i_rd_en(rd_en), .o_dout(s_dout), .o_empty(s_empty),
    .o_almost_empty(s_aempty), .o_count(s_count), .o_overflow(s_ovf),
    .o_underflow(s_udf), .i_clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_en = 0; rd_en = 0; clr_err = 0; din = '0;
    arst_n = 0;
    tick();
    tick();
    arst_n = 1;
    tick();
  endtask

  initial begin
    int exp_cnt;
    do_reset();

    // Reset state
    chk("rst_f_empty", f_empty, 1);
    chk("rst_f_aempty", f_aempty, 1);
    chk("rst_f_count", f_count, 0);
    chk("rst_f_full", f_full, 0);
    chk("rst_f_afull", f_afull, 0);
    chk("rst_f_flags", {f_ovf, f_udf}, 0);
    chk("rst_f_dout", f_dout, 0);
    chk("rst_s_empty", s_empty, 1);
    chk("rst_s_count", s_count, 0);

    // FWFT single-word latency
    wr_en = 1; din = 32'hA5A5_0001;
    tick();
    wr_en = 0;
    chk("fw1_empty_e1", f_empty, 1);
    chk("fw1_count_e1", f_count, 1);
    tick();
    chk("fw1_empty_e2", f_empty, 0);
    chk("fw1_dout_e2", f_dout, 32'hA5A5_0001);
    rd_en = 1;
    tick();
    rd_en = 0;
    chk("fw1_empty_pop", f_empty, 1);
    chk("fw1_count_pop", f_count, 0);
    chk("fw1_udf_pop", f_udf, 0);

    // FWFT fill 17, overflow, drain
    do_reset();
    for (int i = 0; i < 17; i++) begin
      wr_en = 1; din = i;
      tick();
      exp_cnt = i + 1;
      chk("fill_count", f_count, exp_cnt);
      chk("fill_full", f_full, (exp_cnt == 17));
      chk("fill_afull", f_afull, (exp_cnt >= 14));
      chk("fill_aempty", f_aempty, (exp_cnt <= 2));
    end
    din = 32'h99;
    tick();
    wr_en = 0;
    chk("ovf_flag", f_ovf, 1);
    chk("ovf_count", f_count, 17);
    chk("ovf_full", f_full, 1);
    rd_en = 1;
    for (int i = 0; i < 17; i++) begin
      chk("drain_dout", f_dout, i);
      chk("drain_empty", f_empty, 0);
      tick();
    end
    rd_en = 0;
    chk("drain_done_empty", f_empty, 1);
    chk("drain_done_count", f_count, 0);
    chk("drain_no_udf", f_udf, 0);

    // Standard mode registered read
    do_reset();
    wr_en = 1;
    for (int i = 0; i < 3; i++) begin
      din = 32'h11 * (i + 1);
      tick();
    end
    wr_en = 0;
    chk("std_count3", s_count, 3);
    chk("std_empty3", s_empty, 0);
    chk("std_dout_idle", s_dout, 0);
    rd_en = 1;
    tick();
    rd_en = 0;
    chk("std_dout1", s_dout, 32'h11);
    chk("std_count2", s_count, 2);
    tick();
    chk("std_dout_hold", s_dout, 32'h11);
    rd_en = 1;
    tick();
    rd_en = 0;
    chk("std_dout2", s_dout, 32'h22);
    chk("std_count1", s_count, 1);
    chk("std_aempty", s_aempty, 1);

    // Streaming at count 8 with pointer wrap (FWFT)
    do_reset();
    wr_en = 1;
    for (int i = 0; i < 8; i++) begin
      din = 100 + i;
      tick();
    end
    chk("stream_start_count", f_count, 8);
    rd_en = 1;
    for (int k = 0; k < 40; k++) begin
      din = 108 + k;
      chk("stream_dout", f_dout, 100 + k);
      tick();
      chk("stream_count", f_count, 8);
    end
    wr_en = 0; rd_en = 0;
    chk("stream_dout_end", f_dout, 140);

    // Underflow, clear collision, clear
    do_reset();
    rd_en = 1;
    tick();
    rd_en = 0;
    chk("udf_f", f_udf, 1);
    chk("udf_s", s_udf, 1);
    rd_en = 1; clr_err = 1;
    tick();
    rd_en = 0;
    chk("udf_clr_collide", f_udf, 1);
    tick();
    clr_err = 0;
    chk("udf_clr_f", f_udf, 0);
    chk("udf_clr_s", s_udf, 0);

    // Asynchronous reset mid-burst
    wr_en = 1;
    for (int i = 0; i < 5; i++) begin
      din = 32'hB0 + i;
      tick();
    end
    chk("burst_count", f_count, 5);
    arst_n = 0;
    #1;
    chk("arst_count", f_count, 0);
    chk("arst_empty", f_empty, 1);
    chk("arst_dout", f_dout, 0);
    chk("arst_aempty", f_aempty, 1);
    chk("arst_s_count", s_count, 0);
    wr_en = 0;
    tick();
    arst_n = 1;
    tick();
    chk("arst_after_empty", f_empty, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
